// File: rtl/baser_pkg.sv
// Shared 10GBASE-R constants: sync headers, idle block, scrambler/PRBS31 seeds,
// and a word-wide PRBS31 generator step.
package baser_pkg;

  localparam logic [1:0]  SYNC_DATA       = 2'b01;
  localparam logic [1:0]  SYNC_CTRL       = 2'b10;
  localparam logic [7:0]  BLOCK_TYPE_CTRL = 8'h1E;
  localparam logic [63:0] IDLE_BLOCK      = {56'h0, BLOCK_TYPE_CTRL};

  localparam int unsigned SCR_W           = 58;
  localparam logic [57:0] SCRAMBLER_SEED  = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [30:0] PRBS31_SEED     = 31'h7FFF_FFFF;

  // Returns {next_state, word}; word bit 0 is the first bit on the line.
  function automatic logic [62:0] prbs31_advance(input logic [30:0] state);
    logic [30:0] s;
    logic [31:0] w;
    s = state;
    w = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      w[i] = s[30] ^ s[27];
      s    = {s[29:0], w[i]};
    end
    return {s, w};
  endfunction

endpackage

// File: rtl/baser_scrambler_64.sv
// Combinational self-synchronous x^58+x^39+1 scrambler over one 64-bit payload,
// bit 0 processed first.
module baser_scrambler_64
  import baser_pkg::*;
(
  input  logic [63:0]      data_in,
  input  logic [SCR_W-1:0] state_in,
  output logic [63:0]      data_out,
  output logic [SCR_W-1:0] state_out
);

  logic [SCR_W-1:0] s;
  logic             fb;

  always_comb begin
    s        = state_in;
    fb       = 1'b0;
    data_out = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      fb          = data_in[i] ^ s[38] ^ s[57];
      data_out[i] = fb;
      s           = {s[56:0], fb};
    end
    state_out = s;
  end

endmodule

// File: rtl/baser_tx_scrambler_gearbox.sv
// 10GBASE-R TX: scrambles 66-bit blocks and gearboxes them onto 32-bit words.
// Optional PRBS31 test-pattern output when BASER_TX_PRBS31_EN is defined.
module baser_tx_scrambler_gearbox
  import baser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned HDR_WIDTH    = 2,
  parameter int unsigned SERDES_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]    encoded_tx_hdr,
  input  logic                    encoded_tx_valid,
  output logic                    encoded_tx_ready,
  output logic [SERDES_WIDTH-1:0] serdes_tx_data,
  output logic                    error_underflow
`ifdef BASER_TX_PRBS31_EN
  ,
  input  logic                    prbs31_enable
`endif
);

  localparam int unsigned BLK_W = DATA_WIDTH + HDR_WIDTH;
  localparam int unsigned BUF_W = BLK_W + SERDES_WIDTH;
  localparam int unsigned CNT_W = $clog2(BUF_W);

  logic [BUF_W-1:0]        buf_q;
  logic [BUF_W-1:0]        merged;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_next;
  logic [SCR_W-1:0]        scr_q;
  logic [SCR_W-1:0]        scr_next;
  logic [DATA_WIDTH-1:0]   blk_data;
  logic [DATA_WIDTH-1:0]   scr_data;
  logic [HDR_WIDTH-1:0]    blk_hdr;
  logic [SERDES_WIDTH-1:0] tx_word;
  logic                    load;
  logic                    accept;
  logic                    err_d;

  assign load   = cnt_q < CNT_W'(SERDES_WIDTH);
  assign accept = encoded_tx_ready & encoded_tx_valid;

  baser_scrambler_64 u_scrambler (
    .data_in   (blk_data),
    .state_in  (scr_q),
    .data_out  (scr_data),
    .state_out (scr_next)
  );

  // Whenever fewer than a word of bits remains, a block (real or idle) is merged
  // in above them, so every cycle has a full word to emit.
  always_comb begin
    blk_hdr  = SYNC_CTRL;
    blk_data = IDLE_BLOCK;
    if (accept) begin
      blk_hdr  = encoded_tx_hdr;
      blk_data = encoded_tx_data;
    end
    merged   = buf_q;
    cnt_next = cnt_q - CNT_W'(SERDES_WIDTH);
    if (load) begin
      merged   = buf_q | (BUF_W'({scr_data, blk_hdr}) << cnt_q);
      cnt_next = cnt_q + CNT_W'(BLK_W) - CNT_W'(SERDES_WIDTH);
    end
  end

`ifdef BASER_TX_PRBS31_EN
  logic [30:0] prbs_q;
  logic [30:0] prbs_next;
  logic [31:0] prbs_word;

  assign {prbs_next, prbs_word} = prbs31_advance(prbs_q);
  assign tx_word = prbs31_enable ? prbs_word : merged[SERDES_WIDTH-1:0];
  assign err_d   = load & encoded_tx_ready & ~encoded_tx_valid & ~prbs31_enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prbs_q <= PRBS31_SEED;
    end else if (prbs31_enable) begin
      prbs_q <= prbs_next;
    end
  end
`else
  assign tx_word = merged[SERDES_WIDTH-1:0];
  assign err_d   = load & encoded_tx_ready & ~encoded_tx_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q            <= '0;
      cnt_q            <= '0;
      scr_q            <= SCRAMBLER_SEED;
      serdes_tx_data   <= '0;
      encoded_tx_ready <= 1'b0;
      error_underflow  <= 1'b0;
    end else begin
      buf_q            <= merged >> SERDES_WIDTH;
      cnt_q            <= cnt_next;
      serdes_tx_data   <= tx_word;
      encoded_tx_ready <= cnt_next < CNT_W'(SERDES_WIDTH);
      error_underflow  <= err_d;
      if (load) begin
        scr_q <= scr_next;
      end
    end
  end

endmodule

// File: tb/tb_baser_tx_scrambler_gearbox.sv
// Directed bench for baser_tx_scrambler_gearbox: hand-derived words after reset,
// descrambling receiver for block recovery, ready cadence, underflow and PRBS31.
module tb_baser_tx_scrambler_gearbox;

  localparam logic [65:0] IDLE66 = {64'h0000_0000_0000_001E, 2'b10};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] encoded_tx_data = '0;
  logic [1:0]  encoded_tx_hdr = 2'b01;
  logic        encoded_tx_valid = 1'b0;
  logic        encoded_tx_ready;
  logic [31:0] serdes_tx_data;
  logic        error_underflow;
  logic        prbs_sel = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [65:0] exp_q[$];
  bit          rx_bits[$];
  bit          prbs_hist[$];
  logic        ready_hist[$];
  logic [57:0] dscr = '1;
  bit          live = 1'b0;
  bit          record_ready = 1'b0;
  int unsigned drop_left = 0;
  int unsigned err_seen = 0;
  int unsigned ready_cnt = 0;

  baser_tx_scrambler_gearbox #(
    .DATA_WIDTH   (64),
    .HDR_WIDTH    (2),
    .SERDES_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .encoded_tx_data  (encoded_tx_data),
    .encoded_tx_hdr   (encoded_tx_hdr),
    .encoded_tx_valid (encoded_tx_valid),
    .encoded_tx_ready (encoded_tx_ready),
    .serdes_tx_data   (serdes_tx_data),
    .error_underflow  (error_underflow)
`ifdef BASER_TX_PRBS31_EN
    ,
    .prbs31_enable    (prbs_sel)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample #1 after the edge, score the word, then drive next inputs.
  task automatic step();
    logic        was_ready;
    logic        was_valid;
    logic        was_prbs;
    logic [65:0] offered;
    logic [31:0] w;
    logic [31:0] pe;
    bit          have;
    was_ready = encoded_tx_ready;
    was_valid = encoded_tx_valid;
    was_prbs  = prbs_sel;
    offered   = {encoded_tx_data, encoded_tx_hdr};
    @(posedge clk);
    #1;
    w = serdes_tx_data;
    if (live) begin
      if (record_ready) ready_hist.push_back(encoded_tx_ready);
      if (encoded_tx_ready) ready_cnt++;
      check("underflow_pulse", 66'(error_underflow), 66'(was_ready & ~was_valid & ~was_prbs));
      if (error_underflow) err_seen++;
      if (was_prbs) begin
        have = prbs_hist.size() >= 31;
        pe = '0;
        for (int j = 0; j < 32; j++) begin
          int n;
          n = prbs_hist.size();
          pe[j] = (n >= 31) ? (prbs_hist[n-31] ^ prbs_hist[n-28]) : w[j];
          prbs_hist.push_back(w[j]);
          if (prbs_hist.size() > 64) void'(prbs_hist.pop_front());
        end
        if (have) check("prbs31_word", 66'(w), 66'(pe));
      end else begin
        if (was_ready) exp_q.push_back(was_valid ? offered : IDLE66);
        for (int j = 0; j < 32; j++) rx_bits.push_back(w[j]);
        while (rx_bits.size() >= 66) begin
          logic [65:0] blk;
          logic [65:0] exp;
          bit          r;
          for (int j = 0; j < 66; j++) blk[j] = rx_bits.pop_front();
          for (int j = 2; j < 66; j++) begin
            r      = blk[j];
            blk[j] = r ^ dscr[38] ^ dscr[57];
            dscr   = {dscr[56:0], r};
          end
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 66'bx;
          check("recovered_block", blk, exp);
        end
      end
    end
    if (was_ready && was_valid) begin
      encoded_tx_data = {$urandom(), $urandom()};
      encoded_tx_hdr  = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    end
    if (encoded_tx_ready && drop_left > 0) begin
      encoded_tx_valid = 1'b0;
      drop_left--;
    end else begin
      encoded_tx_valid = 1'b1;
    end
  endtask

  task automatic reset_and_release();
    live  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rx_bits.delete();
    dscr = '1;
    exp_q.push_back(IDLE66);
    encoded_tx_data  = '0;
    encoded_tx_hdr   = 2'b01;
    encoded_tx_valid = 1'b1;
    drop_left = 0;
    rst_n = 1'b1;
    live  = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 66'(serdes_tx_data), 66'h0);
    check("rst_ready", 66'(encoded_tx_ready), 66'h0);
    check("rst_underflow", 66'(error_underflow), 66'h0);

    // Priming idle then first data block (all-zero payload, data header)
    record_ready = 1'b1;
    reset_and_release();
    step();
    check("prime_word0", 66'(serdes_tx_data), 66'h0000_007A);
    check("prime_ready0", 66'(encoded_tx_ready), 66'h0);
    step();
    check("prime_word1", 66'(serdes_tx_data), 66'hEFFF_C200);
    check("prime_ready1", 66'(encoded_tx_ready), 66'h1);
    step();
    check("zero_block_word", 66'(serdes_tx_data), 66'hFF84_0005);
    check("zero_block_hdr", 66'(serdes_tx_data[3:2]), 66'h1);

    // Continuous valid: ready cadence over 330 cycles
    while (ready_hist.size() < 330) step();
    record_ready = 1'b0;
    ready_cnt = 0;
    foreach (ready_hist[t]) if (ready_hist[t]) ready_cnt++;
    check("ready_count_330", 66'(ready_cnt), 66'd160);
    for (int t = 33; t < 330; t++) check("ready_period33", 66'(ready_hist[t]), 66'(ready_hist[t-33]));
    check("no_underflow_stream", 66'(err_seen), 66'd0);

    // Underflow: three ready cycles without valid
    err_seen  = 0;
    drop_left = 3;
    repeat (80) step();
    check("underflow_count", 66'(err_seen), 66'd3);
    check("drops_consumed", 66'(drop_left), 66'd0);

    // Reset mid-block: 17 cycles after release the bit count is 50
    reset_and_release();
    repeat (16) step();
    check("pre_reset_ready16", 66'(encoded_tx_ready), 66'h1);
    step();
    check("pre_reset_ready17", 66'(encoded_tx_ready), 66'h0);
    #2;
    live  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 66'(serdes_tx_data), 66'h0);
    check("async_rst_ready", 66'(encoded_tx_ready), 66'h0);
    check("async_rst_underflow", 66'(error_underflow), 66'h0);
    reset_and_release();
    step();
    check("restart_word0", 66'(serdes_tx_data), 66'h0000_007A);
    step();
    check("restart_word1", 66'(serdes_tx_data), 66'hEFFF_C200);
    step();
    check("restart_word2", 66'(serdes_tx_data), 66'hFF84_0005);
    repeat (60) step();

`ifdef BASER_TX_PRBS31_EN
    // PRBS31 test pattern; block consumption cadence must not change
    prbs_sel  = 1'b1;
    ready_cnt = 0;
    repeat (990) step();
    check("prbs_ready_count", 66'(ready_cnt), 66'd480);
    repeat (10) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
